// File: rtl/snes_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : snes_bus_sync
// Purpose  : SNES cartridge bus front end: pin synchronizers, strobe glitch
//            filters (enabled by SNES_BUS_GLITCH_FILTER_EN), access FSM.
// Revision : 1.0
// ============================================================================
module snes_bus_sync #(
  parameter int SYNC_STAGES        = 2,
  parameter int FILTER_LEN         = 3,
  parameter int ADDR_STABLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] SNES_ADDR_IN,
  input  logic [7:0]  SNES_PA_IN,
  input  logic        SNES_READ_IN,
  input  logic        SNES_WRITE_IN,
  input  logic        SNES_PARD_IN,
  input  logic        SNES_PAWR_IN,
  input  logic        SNES_ROMSEL_IN,
  output logic [23:0] SNES_ADDR_early,
  output logic [7:0]  SNES_PA,
  output logic        SNES_ROMSEL,
  output logic        SNES_WRITE_early,
  output logic        SNES_RD_start,
  output logic        SNES_RD_end,
  output logic        SNES_WR_start,
  output logic        SNES_WR_end,
  output logic        SNES_PARD_start,
  output logic        SNES_PAWR_start,
  output logic        addr_stable,
  output logic        bus_conflict
);

  // Packed pin word: {addr, pa, rd, wr, pard, pawr, romsel}; strobes idle high.
  localparam logic [36:0] c_sync_rst = {32'h0, 5'b11111};
  localparam int          c_rd       = 3;
  localparam int          c_wr       = 2;
  localparam int          c_pard     = 1;
  localparam int          c_pawr     = 0;
  localparam logic [3:0]  c_stable   = 4'(ADDR_STABLE_CYCLES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("snes_bus_sync: SYNC_STAGES out of range");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 7) begin : g_bad_filter_len
    $error("snes_bus_sync: FILTER_LEN out of range");
  end
  if (ADDR_STABLE_CYCLES < 1 || ADDR_STABLE_CYCLES > 15) begin : g_bad_stable
    $error("snes_bus_sync: ADDR_STABLE_CYCLES out of range");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_t;

  logic [36:0]            sync_q [SYNC_STAGES];
  logic [36:0]            sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic [36:0]            synced;
  logic [3:0]             strb;
  logic [3:0]             lvl_q, lvl_d;
  state_t                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic                   conflict_q, conflict_d;
  logic                   rd_start_q, rd_start_d, rd_end_q, rd_end_d;
  logic                   wr_start_q, wr_start_d, wr_end_q, wr_end_d;
  logic                   pard_start_q, pard_start_d, pawr_start_q, pawr_start_d;
  logic [23:0]            addr_q, addr_d;
  logic [7:0]             pa_q, pa_d;
  logic                   romsel_q, romsel_d;
  logic [3:0]             stab_cnt_q, stab_cnt_d;

  always_comb begin
    sync_d[0] = {SNES_ADDR_IN, SNES_PA_IN, SNES_READ_IN, SNES_WRITE_IN,
                 SNES_PARD_IN, SNES_PAWR_IN, SNES_ROMSEL_IN};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // flush_q marks when the chain holds only post-reset pin samples.
  assign flush_d = {flush_q[SYNC_STAGES-2:0], 1'b1};
  assign synced  = sync_q[SYNC_STAGES-1];
  assign strb    = synced[4:1];

`ifdef SNES_BUS_GLITCH_FILTER_EN
  localparam logic [2:0] c_filt_len = 3'(FILTER_LEN);

  logic [2:0] cnt_q [4];
  logic [2:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = 3'd0;
      if (strb[i] != lvl_q[i]) begin
        if (cnt_q[i] == c_filt_len) lvl_d[i] = ~lvl_q[i];
        else                        cnt_d[i] = cnt_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) cnt_q[i] <= RST ? 3'd0 : cnt_d[i];
  end
`else
  assign lvl_d = strb;
`endif

  always_comb begin
    state_d      = state_q;
    rd_start_d   = 1'b0;
    rd_end_d     = 1'b0;
    wr_start_d   = 1'b0;
    wr_end_d     = 1'b0;
    // Arming needs real high samples so a reset taken mid-access stays silent.
    armed_d      = armed_q | (flush_q[SYNC_STAGES-1] & lvl_q[c_rd] & lvl_q[c_wr]
                              & strb[c_rd] & strb[c_wr]);
    conflict_d   = conflict_q | (~lvl_d[c_rd] & ~lvl_d[c_wr]);
    pard_start_d = armed_q & lvl_q[c_pard] & ~lvl_d[c_pard];
    pawr_start_d = armed_q & lvl_q[c_pawr] & ~lvl_d[c_pawr];
    case (state_q)
      ST_IDLE: begin
        if (armed_q) begin
          if (lvl_q[c_wr] & ~lvl_d[c_wr]) begin
            state_d    = ST_WR;
            wr_start_d = 1'b1;
          end else if (lvl_q[c_rd] & ~lvl_d[c_rd] & lvl_d[c_wr]) begin
            state_d    = ST_RD;
            rd_start_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (lvl_d[c_rd]) begin
          state_d  = ST_IDLE;
          rd_end_d = 1'b1;
        end
      end
      ST_WR: begin
        if (lvl_d[c_wr]) begin
          state_d  = ST_IDLE;
          wr_end_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = synced[36:13];
    pa_d       = synced[12:5];
    romsel_d   = synced[0];
    stab_cnt_d = stab_cnt_q;
    if (addr_d != addr_q)           stab_cnt_d = 4'd0;
    else if (stab_cnt_q != c_stable) stab_cnt_d = stab_cnt_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= c_sync_rst;
      flush_q      <= '0;
      lvl_q        <= 4'hF;
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      conflict_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      rd_end_q     <= 1'b0;
      wr_start_q   <= 1'b0;
      wr_end_q     <= 1'b0;
      pard_start_q <= 1'b0;
      pawr_start_q <= 1'b0;
      addr_q       <= 24'h0;
      pa_q         <= 8'h0;
      romsel_q     <= 1'b1;
      stab_cnt_q   <= 4'd0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      flush_q      <= flush_d;
      lvl_q        <= lvl_d;
      state_q      <= state_d;
      armed_q      <= armed_d;
      conflict_q   <= conflict_d;
      rd_start_q   <= rd_start_d;
      rd_end_q     <= rd_end_d;
      wr_start_q   <= wr_start_d;
      wr_end_q     <= wr_end_d;
      pard_start_q <= pard_start_d;
      pawr_start_q <= pawr_start_d;
      addr_q       <= addr_d;
      pa_q         <= pa_d;
      romsel_q     <= romsel_d;
      stab_cnt_q   <= stab_cnt_d;
    end
  end

  assign SNES_ADDR_early  = addr_q;
  assign SNES_PA          = pa_q;
  assign SNES_ROMSEL      = romsel_q;
  assign SNES_WRITE_early = lvl_q[c_wr];
  assign SNES_RD_start    = rd_start_q;
  assign SNES_RD_end      = rd_end_q;
  assign SNES_WR_start    = wr_start_q;
  assign SNES_WR_end      = wr_end_q;
  assign SNES_PARD_start  = pard_start_q;
  assign SNES_PAWR_start  = pawr_start_q;
  assign addr_stable      = (stab_cnt_q == c_stable);
  assign bus_conflict     = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_bus_sync.sv
`default_nettype none
// Testbench for snes_bus_sync: directed stimulus pushes expected strobe events
// and level samples into queues; a negedge monitor pops and compares them.
module tb_snes_bus_sync;

  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int STAB  = 2;
  localparam int LAT_A = SYNC + 1;
`ifdef SNES_BUS_GLITCH_FILTER_EN
  localparam int LAT_S = SYNC + FILT + 1;
`else
  localparam int LAT_S = SYNC + 1;
`endif

  localparam int S_RDS = 0, S_RDE = 1, S_WRS = 2, S_WRE = 3, S_PARD = 4, S_PAWR = 5;
  localparam int L_ADDR = 0, L_PA = 1, L_ROMSEL = 2, L_WE = 3, L_STABLE = 4, L_CONFLICT = 5;

  typedef struct { int cyc; int kind; } sexp_t;
  typedef struct { int cyc; int id; logic [23:0] val; } lexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] addr_in = 24'h0;
  logic [7:0]  pa_in = 8'h0;
  logic        rd_in = 1'b1, wr_in = 1'b1, pard_in = 1'b1, pawr_in = 1'b1, romsel_in = 1'b1;
  logic [23:0] addr_early;
  logic [7:0]  pa;
  logic        romsel, write_early;
  logic        rd_start, rd_end, wr_start, wr_end, pard_start, pawr_start;
  logic        stable, conflict;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  sexp_t sq[$];
  lexp_t lq[$];

  snes_bus_sync #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .ADDR_STABLE_CYCLES(STAB)
  ) dut (
    .CLK(clk), .RST(rst),
    .SNES_ADDR_IN(addr_in), .SNES_PA_IN(pa_in),
    .SNES_READ_IN(rd_in), .SNES_WRITE_IN(wr_in),
    .SNES_PARD_IN(pard_in), .SNES_PAWR_IN(pawr_in), .SNES_ROMSEL_IN(romsel_in),
    .SNES_ADDR_early(addr_early), .SNES_PA(pa), .SNES_ROMSEL(romsel),
    .SNES_WRITE_early(write_early),
    .SNES_RD_start(rd_start), .SNES_RD_end(rd_end),
    .SNES_WR_start(wr_start), .SNES_WR_end(wr_end),
    .SNES_PARD_start(pard_start), .SNES_PAWR_start(pawr_start),
    .addr_stable(stable), .bus_conflict(conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sname(int k);
    case (k)
      S_RDS:   return "RD_start";
      S_RDE:   return "RD_end";
      S_WRS:   return "WR_start";
      S_WRE:   return "WR_end";
      S_PARD:  return "PARD_start";
      default: return "PAWR_start";
    endcase
  endfunction

  function automatic string lname(int id);
    case (id)
      L_ADDR:   return "SNES_ADDR_early";
      L_PA:     return "SNES_PA";
      L_ROMSEL: return "SNES_ROMSEL";
      L_WE:     return "SNES_WRITE_early";
      L_STABLE: return "addr_stable";
      default:  return "bus_conflict";
    endcase
  endfunction

  function automatic logic [23:0] lact(int id);
    case (id)
      L_ADDR:   return addr_early;
      L_PA:     return {16'h0, pa};
      L_ROMSEL: return {23'h0, romsel};
      L_WE:     return {23'h0, write_early};
      L_STABLE: return {23'h0, stable};
      default:  return {23'h0, conflict};
    endcase
  endfunction

  // Monitor: match every observed strobe, flag missed ones, sample levels.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [5:0] s;
      s = {pawr_start, pard_start, wr_end, wr_start, rd_end, rd_start};
      for (int k = 0; k < 6; k++) begin
        if (s[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sq.size(); j++)
            if (sq[j].cyc == cyc && sq[j].kind == k) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL %s unexpected at cycle %0d: got 1, expected 0", sname(k), cyc);
          end else begin
            sq.delete(idx);
          end
        end
      end
      for (int j = sq.size() - 1; j >= 0; j--) begin
        if (sq[j].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missing at cycle %0d: got 0, expected 1", sname(sq[j].kind), sq[j].cyc);
          sq.delete(j);
        end
      end
      for (int j = lq.size() - 1; j >= 0; j--) begin
        if (lq[j].cyc == cyc) begin
          checks++;
          if (lact(lq[j].id) !== lq[j].val) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h",
                     lname(lq[j].id), cyc, lact(lq[j].id), lq[j].val);
          end
          lq.delete(j);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_s(input int kind, input int dly);
    sexp_t e;
    e.cyc = cyc + dly; e.kind = kind;
    sq.push_back(e);
  endtask

  task automatic exp_l(input int id, input logic [23:0] val, input int dly);
    lexp_t e;
    e.cyc = cyc + dly; e.id = id; e.val = val;
    lq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    mon_en = 1'b1;
    exp_l(L_ADDR, 24'h0, 1);
    exp_l(L_PA, 24'h0, 1);
    exp_l(L_ROMSEL, 24'h1, 1);
    exp_l(L_WE, 24'h1, 1);
    exp_l(L_STABLE, 24'h0, 1);
    exp_l(L_CONFLICT, 24'h0, 1);
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    do_reset();
    tick(8);

    // Clean read with address change
    addr_in = 24'h808000; rd_in = 1'b0;
    exp_l(L_ADDR, 24'h000000, LAT_A - 1);
    exp_l(L_ADDR, 24'h808000, LAT_A);
    exp_l(L_STABLE, 24'h0, LAT_A + 1);
    exp_l(L_STABLE, 24'h1, LAT_A + 2);
    exp_s(S_RDS, LAT_S);
    tick(20);
    rd_in = 1'b1;
    exp_s(S_RDE, LAT_S);
    tick(12);

    // Two-cycle /WR pulse
`ifdef SNES_BUS_GLITCH_FILTER_EN
    for (int d = 3; d <= 8; d++) exp_l(L_WE, 24'h1, d);
`else
    exp_s(S_WRS, 3);
    for (int d = 3; d <= 8; d++) exp_l(L_WE, (d == 3 || d == 4) ? 24'h0 : 24'h1, d);
`endif
    wr_in = 1'b0;
    tick(2);
    wr_in = 1'b1;
`ifndef SNES_BUS_GLITCH_FILTER_EN
    exp_s(S_WRE, 3);
`endif
    tick(12);

    // PA read and write strobes
    pa_in = 8'h3F; pard_in = 1'b0;
    exp_l(L_PA, 24'h3F, LAT_A);
    exp_s(S_PARD, LAT_S);
    tick(5);
    pard_in = 1'b1;
    tick(10);
    pa_in = 8'hC2; pawr_in = 1'b0;
    exp_l(L_PA, 24'h3F, LAT_A - 1);
    exp_l(L_PA, 24'hC2, LAT_A);
    exp_s(S_PAWR, LAT_S);
    tick(6);
    pawr_in = 1'b1;
    tick(10);

    // ROMSEL pass-through
    romsel_in = 1'b0;
    exp_l(L_ROMSEL, 24'h1, LAT_A - 1);
    exp_l(L_ROMSEL, 24'h0, LAT_A);
    tick(4);
    romsel_in = 1'b1;
    exp_l(L_ROMSEL, 24'h1, LAT_A);
    tick(6);

    // Simultaneous /RD and /WR
    rd_in = 1'b0; wr_in = 1'b0;
    exp_l(L_CONFLICT, 24'h0, LAT_S - 1);
    exp_l(L_CONFLICT, 24'h1, LAT_S);
    exp_l(L_WE, 24'h0, LAT_S);
    exp_s(S_WRS, LAT_S);
    tick(6);
    rd_in = 1'b1; wr_in = 1'b1;
    exp_s(S_WRE, LAT_S);
    exp_l(L_CONFLICT, 24'h1, LAT_S + 6);
    tick(15);

    // Reset in the middle of a read
    rd_in = 1'b0;
    exp_s(S_RDS, LAT_S);
    exp_l(L_CONFLICT, 24'h1, 2);
    tick(10);
    do_reset();
    tick(15);
    rd_in = 1'b1;
    tick(10);
    rd_in = 1'b0;
    exp_s(S_RDS, LAT_S);
    tick(8);
    rd_in = 1'b1;
    exp_s(S_RDE, LAT_S);
    tick(12);

    // Address toggling then holding
    for (int i = 0; i < 8; i++) begin
      addr_in = (i % 2 == 0) ? 24'h00FFFF : 24'h010000;
      exp_l(L_ADDR, addr_in, LAT_A);
      exp_l(L_STABLE, 24'h0, LAT_A);
      if (i == 7) begin
        exp_l(L_STABLE, 24'h0, LAT_A + 1);
        exp_l(L_STABLE, 24'h1, LAT_A + 2);
        exp_l(L_STABLE, 24'h1, LAT_A + 5);
      end
      tick(1);
    end
    tick(12);

    mon_en = 1'b0;
    foreach (sq[j]) begin
      checks++;
      errors++;
      $display("FAIL %s never seen at cycle %0d: got 0, expected 1", sname(sq[j].kind), sq[j].cyc);
    end
    foreach (lq[j]) begin
      checks++;
      errors++;
      $display("FAIL %s not sampled at cycle %0d: got none, expected %h", lname(lq[j].id), lq[j].cyc, lq[j].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
